// File: rtl/sync_fifo_param_pkg.sv
// Shared sizing helpers and read-mode constants for the single-clock FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // One extra pointer bit separates full from empty after wrap-around.
  function automatic int unsigned fifo_ptr_w(input int unsigned addr_size);
    return addr_size + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the single-clock FIFO; slave is the FIFO side.
interface sync_fifo_param_if #(
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned ADDRESS_SIZE = 4
);
  logic                    flush;
  logic                    clr_err;
  logic                    wr_en;
  logic [DATASIZE-1:0]     wdata;
  logic                    rd_en;
  logic [DATASIZE-1:0]     rdata;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ADDRESS_SIZE:0]   count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output flush, clr_err, wr_en, wdata, rd_en,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wdata, rd_en,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module sync_fifo_mem #(
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [ADDRESS_SIZE-1:0] i_waddr,
  input  logic [DATASIZE-1:0]     i_wdata,
  input  logic [ADDRESS_SIZE-1:0] i_raddr,
  output logic [DATASIZE-1:0]     o_rdata
);
  localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;

  logic [DATASIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors,
// synchronous flush and standard or first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned FWFT         = FIFO_MODE_STD,
  parameter int unsigned AF_LEVEL     = fifo_depth(ADDRESS_SIZE) - 4,
  parameter int unsigned AE_LEVEL     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned DEPTH = fifo_depth(ADDRESS_SIZE);
  localparam int unsigned PW    = fifo_ptr_w(ADDRESS_SIZE);

  logic [PW-1:0]       r_wr_ptr, r_rd_ptr, r_count;
  logic [PW-1:0]       w_wr_ptr_d, w_rd_ptr_d;
  logic                r_overflow, r_underflow;
  logic                w_full, w_empty, w_wr_fire, w_rd_fire;
  logic [DATASIZE-1:0] w_mem_rdata;

  assign w_full    = (r_count == PW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Flush wins over both requests; acceptance is judged on pre-edge state.
  assign w_wr_fire = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rd_fire = bus.rd_en & ~w_empty & ~bus.flush;

  always_comb begin
    w_wr_ptr_d = r_wr_ptr + PW'(w_wr_fire);
    w_rd_ptr_d = r_rd_ptr + PW'(w_rd_fire);
    if (bus.flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_wr_ptr_d - w_rd_ptr_d;
    end
  end

  // A set in the same cycle as clr_err wins by being assigned last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (!bus.flush && bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (!bus.flush && bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATASIZE     (DATASIZE),
    .ADDRESS_SIZE (ADDRESS_SIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr[ADDRESS_SIZE-1:0]),
    .i_wdata (bus.wdata),
    .i_raddr (r_rd_ptr[ADDRESS_SIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.rdata = w_mem_rdata;
    end else begin : g_std
      logic [DATASIZE-1:0] r_rdata;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_rdata <= '0;
        else if (w_rd_fire) r_rdata <= w_mem_rdata;
      end
      assign bus.rdata = r_rdata;
    end
  endgenerate

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= PW'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= PW'(AE_LEVEL));
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
